// File: rtl/regfile_mp.sv
// regfile_mp: dual-read, single-write register file with registered reads,
// optional hardwired-zero entry 0, optional write-to-read bypass and a
// self-clearing sweep that zeroes every entry after reset.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clear_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_to_zero;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_accept;

    // Read-port value for one address: zero entry first, then bypass, then array.
    function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if ((ZERO_REG != 0) && (addr == '0))
            val = '0;
        else if ((BYPASS != 0) && wr_en && (wr_addr == addr))
            val = wr_data;
        else
            val = mem[addr];
        return val;
    endfunction

    assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign rd_accept  = rst_n && (state == READY) && rd_en;

    // Array write port: the clear sweep owns it during CLEAR, writeback during READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (rst_n) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clear_ptr;
                mem_wdata = '0;
            end else if (wr_en && !wr_to_zero) begin
                mem_we = 1'b1;
            end
        end
    end

    // Sweep/ready control; clear_ptr stops at the last entry so it never re-sweeps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_ptr == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        clear_ptr <= clear_ptr + ADDR_W'(1);
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array; contents are untouched by reset and cleared by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Registered read ports; data holds its last value when no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data_a <= read_sel(rd_addr_a);
                rd_data_b <= read_sel(rd_addr_b);
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a BYPASS=1 and a BYPASS=0 instance with identical
// stimulus and compares both against a behavioural register-file model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] rda1, rdb1, rda0, rdb0;
    logic        vld1, vld0, busy1, busy0;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [31:0] m_mem [32];
    int          m_swept;      // entries cleared since last release, 32 = done
    logic        m_vld;
    logic [31:0] m_a1, m_b1, m_a0, m_b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda1), .rd_data_b(rdb1), .rd_valid(vld1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda0), .rd_data_b(rdb0), .rd_valid(vld0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected read value of one port, from register-file rules.
    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    // Advance the model by one posedge using the inputs present at that edge.
    task automatic m_edge();
        if (!rst_n) begin
            m_swept = 0;
            m_vld   = 1'b0;
            m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
        end else if (m_swept < 32) begin
            m_mem[m_swept] = 32'h0;
            m_swept++;
            m_vld = 1'b0;
        end else begin
            m_vld = rd_en;
            if (rd_en) begin
                m_a1 = m_read(rd_addr_a, 1'b1);
                m_b1 = m_read(rd_addr_b, 1'b1);
                m_a0 = m_read(rd_addr_a, 1'b0);
                m_b0 = m_read(rd_addr_b, 1'b0);
            end
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("busy_byp",   {31'b0, busy1}, {31'b0, (m_swept < 32)});
        chk("busy_nobyp", {31'b0, busy0}, {31'b0, (m_swept < 32)});
        chk("vld_byp",    {31'b0, vld1},  {31'b0, m_vld});
        chk("vld_nobyp",  {31'b0, vld0},  {31'b0, m_vld});
        chk("rda_byp",    rda1, m_a1);
        chk("rdb_byp",    rdb1, m_b1);
        chk("rda_nobyp",  rda0, m_a0);
        chk("rdb_nobyp",  rdb0, m_b0);
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0;
        rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        idle(); wr_en = 1; wr_addr = a; wr_data = d;
        step();
        idle();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        idle(); rd_en = 1; rd_addr_a = a; rd_addr_b = b;
        step();
        idle();
    endtask

    // Count edges from release until busy drops; also pokes writes/reads while busy.
    task automatic sweep_len(input string tag, input bit poke);
        int n = 0;
        rst_n = 1;
        while (n < 100) begin
            if (poke) begin
                wr_en = 1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF;
                rd_en = 1; rd_addr_a = 5'd9; rd_addr_b = 5'($urandom_range(0, 31));
            end
            step();
            n++;
            if (!busy1) break;
        end
        idle();
        chk(tag, n, 32);
    endtask

    task automatic do_reset(input int cycles);
        idle(); rst_n = 0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            chk({tag, "_a"}, rda1, 32'h0);
            chk({tag, "_v"}, {31'b0, vld1}, 32'h1);
        end
    endtask

    initial begin
        m_swept = 0; m_vld = 0;
        m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
        idle();

        // initial reset and sweep
        do_reset(2);
        chk("reset_busy", {31'b0, busy1}, 32'h1);
        chk("reset_vld",  {31'b0, vld1},  32'h0);
        sweep_len("sweep_len0", 1'b0);

        // fill with garbage, then reset; sweep must clear it and ignore traffic
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom | 32'h1);
        do_reset(2);
        sweep_len("sweep_len1", 1'b1);
        step();
        read_all_zero("swept");
        do_read(5'd9, 5'd9);
        chk("clear_ignored_r9", rda1, 32'h0);

        // basic write then read on both ports
        do_write(5'd8, 32'hDEAD_BEEF);
        do_read(5'd8, 5'd8);
        chk("basic_a", rda1, 32'hDEAD_BEEF);
        chk("basic_b", rdb1, 32'hDEAD_BEEF);
        chk("basic_v", {31'b0, vld1}, 32'h1);
        step();
        chk("hold_v", {31'b0, vld1}, 32'h0);
        chk("hold_a", rda1, 32'hDEAD_BEEF);

        // zero register ignores writes
        do_write(5'd0, 32'h1234_5678);
        do_read(5'd0, 5'd8);
        chk("zero_a", rda1, 32'h0);

        // same-cycle bypass vs. no bypass
        do_write(5'd4, 32'd5);
        do_write(5'd3, 32'h0000_1111);
        idle(); wr_en = 1; wr_addr = 5'd3; wr_data = 32'h0000_AAAA;
        rd_en = 1; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        step();
        idle();
        chk("byp_a",   rda1, 32'h0000_AAAA);
        chk("byp_b",   rdb1, 32'd5);
        chk("nobyp_a", rda0, 32'h0000_1111);
        chk("nobyp_b", rdb0, 32'd5);
        do_read(5'd3, 5'd3);
        chk("after_nobyp_a", rda0, 32'h0000_AAAA);

        // zero register wins over bypass
        idle(); wr_en = 1; wr_addr = 5'd0; wr_data = 32'hCAFE_F00D;
        rd_en = 1; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        step();
        idle();
        chk("zero_byp_a", rda1, 32'h0);

        // reset mid-sweep restarts a full sweep
        do_reset(1);
        rst_n = 1;
        for (int i = 0; i < 10; i++) step();
        do_reset(1);
        sweep_len("sweep_len_mid", 1'b0);
        read_all_zero("mid");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr_en     = 1'($urandom);
            wr_addr   = 5'($urandom);
            wr_data   = $urandom;
            rd_en     = 1'($urandom);
            rd_addr_a = 5'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
